// File: rtl/arith_pkg.sv
// arith_pkg: shared width and operation-select encoding for the arithmetic datapath
package arith_pkg;
    localparam int DATA_W = 32;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell of the ripple-carry chain
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/adder_subtractor_32bit.sv
// adder_subtractor_32bit: ripple-carry add/subtract with registered result and flags
module adder_subtractor_32bit
    import arith_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sel,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    logic [WIDTH-1:0] beff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c;
    // subtraction is A + ~B + 1
    assign c[0] = (sel == OP_SUB);
    assign beff = B ^ {WIDTH{c[0]}};
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a (A[i]),
            .b (beff[i]),
            .ci(c[i]),
            .s (sum[i]),
            .co(c[i+1])
        );
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            S        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            S        <= sum;
            cout     <= c[WIDTH];
            overflow <= c[WIDTH] ^ c[WIDTH-1];
            zero     <= ~|sum;
        end
    end
endmodule

// File: tb/tb_adder_subtractor_32bit.sv
// tb_adder_subtractor_32bit: scoreboard bench with arithmetic reference model
module tb_adder_subtractor_32bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        sel = 1'b0;
    logic [31:0] S;
    logic        cout, overflow, zero;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cycle = 0;

    adder_subtractor_32bit dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .sel(sel),
        .S(S), .cout(cout), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic r, input logic [31:0] a, input logic [31:0] b, input logic op);
        exp_t e;
        longint ua, ub, full, sa, sb, sres;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op) begin
            full = ua - ub;
            sres = sa - sb;
            e.c  = (ua >= ub);
        end else begin
            full = ua + ub;
            sres = sa + sb;
            e.c  = (full >= 64'sh1_0000_0000);
        end
        e.s = full[31:0];
        e.v = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
        e.z = (e.s == 32'h0);
        if (r) begin
            e.s = '0;
            e.c = 1'b0;
            e.v = 1'b0;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b, input logic op);
        @(negedge clk);
        rst = r;
        A   = a;
        B   = b;
        sel = op;
        q.push_back(model(r, a, b, op));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, req);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("S", S, e.s);
                chk("cout", {31'b0, cout}, {31'b0, e.c});
                chk("overflow", {31'b0, overflow}, {31'b0, e.v});
                chk("zero", {31'b0, zero}, {31'b0, e.z});
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        step(1, 32'h1234_5678, 32'h1, 0);
        step(1, 32'h1234_5678, 32'h1, 0);
        step(0, 32'h0, 32'h0, 0);
        step(0, 32'h1, 32'h1, 0);
        step(0, 32'h2, 32'h1, 1);
        step(0, 32'hFFFF_FFFF, 32'h1, 0);
        step(0, 32'h0, 32'h1, 1);
        step(0, 32'h7FFF_FFFF, 32'h1, 0);
        step(0, 32'h8000_0000, 32'h1, 1);
        step(0, 32'h5, 32'h5, 1);
        for (int i = 0; i < 1000; i++) begin
            step(i == 500, pick(), pick(), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_subtractor_32bit.md
Name: adder_subtractor_32bit

Overview:
- 32-bit two's-complement adder/subtractor with registered outputs.
- sel=0 computes A+B; sel=1 computes A-B.
- Used as the arithmetic datapath primitive feeding ALU-level logic.
- Core is a ripple-carry chain of full adders: subtraction inverts B and injects carry-in = 1. The result and status flags are captured on the clock edge.

Parameters:
- WIDTH, 32, operand/result width in bits (all checks below use 32).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- sel  input  1  operation select: 0 = add (A+B), 1 = subtract (A-B)
- S  output  WIDTH  registered result
- cout  output  1  registered carry-out of MSB (for subtract: 1 = no borrow, i.e. A >= B unsigned)
- overflow  output  1  registered signed overflow, = carry into MSB XOR carry out of MSB
- zero  output  1  registered flag, 1 when the computed result is all zeros

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). No asynchronous reset path.
- Reset: on a rising clk edge with rst=1, S=0, cout=0, overflow=0, zero=0. Reset has priority over the capture of new operands.
- Operand transform: Beff = B XOR {WIDTH{sel}}; cin = sel.
- Combinational sum: {c_out, sum} = A + Beff + cin, computed as a ripple chain of WIDTH full adders (bit i carry-in = bit i-1 carry-out; bit 0 carry-in = cin).
- Latency: exactly 1 cycle. A, B and sel sampled at rising edge N appear on S/cout/overflow/zero after edge N. No handshake; a new operation is accepted every cycle (throughput 1/cycle).
- Width rule: result is modulo 2^WIDTH and wraps silently. The wrap is reported only via cout/overflow; no saturation.
- Subtract with A<B (unsigned): S = A-B mod 2^32 and cout=0. For example, 0-1 gives S=0xFFFFFFFF, cout=0.
- Signed overflow examples:
  - 0x7FFFFFFF+1 gives S=0x80000000, overflow=1, cout=0.
  - 0x80000000-1 gives S=0x7FFFFFFF, overflow=1, cout=1.
- zero is derived from the registered-stage sum; it is 1 whenever the result is 0. For example, 5-5 gives zero=1, cout=1.
- Reset deasserted mid-stream: the first edge with rst=0 captures the current inputs. There are no pipeline bubbles beyond that edge.
- Inputs changing between edges have no effect until the next rising edge.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package (arith_pkg): localparam DATA_W = 32; constants OP_ADD = 1'b0 and OP_SUB = 1'b1 for sel encoding.
- Sub-module: full_adder (inputs a, b, ci; outputs s, co), instantiated WIDTH times via a generate loop.
- Top level holds the B-inversion XOR, carry chain wiring, flag logic and output registers.

Test Plan:
- Reset: hold rst=1 with A=0x12345678, B=1, sel=0 for 2 edges -> S=0, cout=0, overflow=0, zero=0. Then A=0, B=0, sel=0, rst=0 for 1 edge -> S=0, zero=1.
- Add: A=1, B=1, sel=0 -> one edge later S=2, cout=0, overflow=0, zero=0.
- Subtract: A=2, B=1, sel=1 -> one edge later S=1, cout=1, overflow=0, zero=0.
- Wrap/borrow: A=0xFFFFFFFF, B=1, sel=0 -> S=0, cout=1, zero=1. Then A=0, B=1, sel=1 -> S=0xFFFFFFFF, cout=0.
- Signed overflow: A=0x7FFFFFFF, B=1, sel=0 -> S=0x80000000, overflow=1. Then A=0x80000000, B=1, sel=1 -> S=0x7FFFFFFF, overflow=1.
- Back-to-back throughput: change A/B/sel every cycle with 1000 random vectors, including toggling sel. The bench compares each output against a reference model of the previous-cycle inputs (mod 2^32 result, carry, signed overflow, zero). Assert rst once mid-run -> outputs 0 on the following edge, then correct results resume on the next edge.
